// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit engine: FSM encoding and frame constants.
package uart_pkg;

  localparam int DIV_W_DEFAULT = 16;
  localparam int DATA_BITS     = 8;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter: loads a divisor and counts to zero, where it holds and flags tick.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= div_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, one stop bit.
// Handshake: a frame starts on a rising edge of ctl_i[0] seen while idle (or in the done_o cycle);
// busy_o covers every START..STOP cycle, done_o pulses once on return to idle, requests while busy are dropped.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       ctl_i,
  input  logic [7:0]       tx_data_i,
  input  logic [DIV_W-1:0] baud_div_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [2:0]       dbg_state_o
);

  state_e           state_q, state_d;
  logic             req_q;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic             start_req;
  logic             load;
  logic [DIV_W-1:0] load_val;
  logic             tick;

  assign start_req = ctl_i[0] & ~req_q;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load),
    .div_i  (load_val),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    data_d   = data_q;
    par_d    = par_q;
    div_d    = div_q;
    idx_d    = idx_q;
    load     = 1'b0;
    load_val = div_q;
    unique case (state_q)
      S_IDLE: begin
        tx_d = IDLE_LEVEL;
        if (start_req) begin
          state_d  = S_START;
          tx_d     = 1'b0;
          data_d   = tx_data_i;
          par_d    = ctl_i[1];
          div_d    = baud_div_i;
          load     = 1'b1;
          load_val = baud_div_i;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          tx_d    = data_q[0];
          idx_d   = 3'd0;
          load    = 1'b1;
        end
      end
      S_DATA: begin
        if (tick) begin
          load = 1'b1;
          if (idx_q == 3'(DATA_BITS - 1)) begin
            idx_d = 3'd0;
            if (par_q) begin
              state_d = S_PARITY;
              tx_d    = ^data_q;
            end else begin
              state_d = S_STOP;
              tx_d    = IDLE_LEVEL;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_q + 3'd1];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          tx_d    = IDLE_LEVEL;
          load    = 1'b1;
        end
      end
      S_STOP: begin
        // Counter is left at zero here so it rests idle without reloading.
        if (tick) begin
          state_d = S_IDLE;
          tx_d    = IDLE_LEVEL;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      tx_q    <= IDLE_LEVEL;
      done_q  <= 1'b0;
      data_q  <= '0;
      par_q   <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= ctl_i[0];
      tx_q    <= tx_d;
      done_q  <= done_d;
      data_q  <= data_d;
      par_q   <= par_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
    end
  end

  assign tx_o        = tx_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Randomized scoreboard bench for uart_tx_engine: driver queues expected frames, monitor checks the line.
module tb_uart_tx_engine;

  localparam int DIV_W = 16;
  localparam int W     = 57;  // {start_cycle[31:0], div[15:0], parity_en, data[7:0]}

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [1:0]       ctl_i;
  logic [7:0]       tx_data_i;
  logic [DIV_W-1:0] baud_div_i;
  logic             tx_o;
  logic             busy_o;
  logic             done_o;
  logic [2:0]       dbg_state;

  uart_tx_engine #(.DIV_W(DIV_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ctl_i       (ctl_i),
    .tx_data_i   (tx_data_i),
    .baud_div_i  (baud_div_i),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk_i = ~clk_i;

  int   cyc = 0;
  logic rst_q = 1'b0;
  initial begin
    forever begin
      @(posedge clk_i);
      cyc   = cyc + 1;
      rst_q = rst_ni;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line level for symbol idx of a frame: start, 8 data LSB first, parity if enabled, stop.
  function automatic logic exp_bit(input logic [7:0] d, input logic p, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && p) return ^d;
    return 1'b1;
  endfunction

  // ---------------- monitor ----------------
  int           mode = 0;  // 0 idle, 1 in frame, 2 expect done, 3 unexpected frame
  int           pos, bit_len, total;
  logic [7:0]   cur_d;
  logic         cur_p;
  logic [W-1:0] e;

  initial begin
    forever begin
      @(negedge clk_i);
      if (cyc >= 1) begin
        if (!rst_q) begin
          check("rst_tx", tx_o, 1);
          check("rst_busy", busy_o, 0);
          check("rst_done", done_o, 0);
          mode = 0;
          exp_q.delete();
        end else begin
          if (mode == 2) begin
            check("done_pulse", done_o, 1);
            check("done_busy", busy_o, 0);
            check("done_tx", tx_o, 1);
            mode = 0;
          end else if (mode == 3) begin
            if (!busy_o) mode = 0;
          end else if (mode == 0) begin
            if (busy_o) begin
              if (exp_q.size() == 0) begin
                check("unexpected_frame", 1, 0);
                mode = 3;
              end else begin
                e       = exp_q.pop_front();
                check("start_cycle", cyc, e[56:25]);
                cur_d   = e[7:0];
                cur_p   = e[8];
                bit_len = int'(e[24:9]) + 1;
                total   = (cur_p ? 11 : 10) * bit_len;
                pos     = 0;
                mode    = 1;
              end
            end else begin
              check("idle_tx", tx_o, 1);
              check("idle_done", done_o, 0);
            end
          end
          if (mode == 1) begin
            check("tx_bit", tx_o, exp_bit(cur_d, cur_p, pos / bit_len));
            check("busy", busy_o, 1);
            check("done_early", done_o, 0);
            pos++;
            if (pos == total) mode = 2;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] d, input logic p, input logic [DIV_W-1:0] dv,
                      input bit skip_zero);
    if (!skip_zero) begin
      ctl_i[0] = 1'b0;
      @(negedge clk_i);
    end
    tx_data_i  = d;
    baud_div_i = dv;
    ctl_i      = {p, 1'b1};
    exp_q.push_back({32'(cyc + 1), dv, p, d});
    @(negedge clk_i);
    // Inputs wander after the request; the frame must keep its latched values.
    tx_data_i  = 8'($urandom);
    baud_div_i = DIV_W'($urandom_range(0, 7));
    ctl_i[1]   = 1'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) return;
    end
    check("done_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  bit b2b;

  initial begin
    rst_ni     = 1'b0;
    ctl_i      = 2'b00;
    tx_data_i  = 8'h00;
    baud_div_i = '0;
    repeat (3) @(negedge clk_i);

    // Request present in the very first cycle after reset release.
    rst_ni = 1'b1;
    send(8'h5A, 1'b0, 16'd1, 1'b1);
    wait_done();

    send(8'h55, 1'b0, 16'd3, 1'b0);
    wait_done();
    send(8'h07, 1'b1, 16'd3, 1'b0);
    wait_done();

    // Level held high for 100 cycles must give one frame only.
    send(8'hA3, 1'b0, 16'd0, 1'b0);
    repeat (100) @(negedge clk_i);
    ctl_i[0] = 1'b0;
    @(negedge clk_i);

    // Re-request and data change mid-frame are ignored.
    send(8'h3C, 1'b1, 16'd2, 1'b0);
    ctl_i[0] = 1'b0;
    @(negedge clk_i);
    ctl_i[0]  = 1'b1;
    tx_data_i = 8'hFF;
    @(negedge clk_i);
    ctl_i[0] = 1'b0;
    wait_done();

    // New request in the done cycle starts immediately.
    send(8'h81, 1'b1, 16'd1, 1'b0);
    ctl_i[0] = 1'b0;
    wait_done();
    send(8'h18, 1'b0, 16'd2, 1'b1);
    wait_done();

    // Reset while data bit 3 is on the line, then a clean frame.
    send(8'hC6, 1'b0, 16'd2, 1'b0);
    repeat (12) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni   = 1'b1;
    ctl_i[0] = 1'b0;
    repeat (3) @(negedge clk_i);
    send(8'h96, 1'b1, 16'd2, 1'b0);
    wait_done();

    // Randomized frames with optional mid-frame toggles and back-to-back starts.
    b2b = 1'b0;
    for (int i = 0; i < 24; i++) begin
      send(8'($urandom), 1'($urandom_range(0, 1)), DIV_W'($urandom_range(0, 4)), b2b);
      if ($urandom_range(0, 1) == 1) begin
        ctl_i[0] = 1'b0;
        @(negedge clk_i);
        ctl_i[0] = 1'b1;
        @(negedge clk_i);
      end
      ctl_i[0] = 1'b0;
      b2b      = 1'($urandom_range(0, 1));
      wait_done();
      if (!b2b) repeat ($urandom_range(0, 3)) @(negedge clk_i);
    end

    repeat (6) @(negedge clk_i);
    check("queue_empty", exp_q.size(), 0);
    check("monitor_idle", mode, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the baud divisor input.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low (sampled on clk_i rising edge; low = reset).
REQ-004 SHALL have port ctl_i, input, 2 bits: control word from the 2-bit control register; bit0 = transmit request, bit1 = even-parity enable.
REQ-005 SHALL have port tx_data_i, input, 8 bits: byte to transmit.
REQ-006 SHALL have port baud_div_i, input, DIV_W bits: bit period minus one, in clk_i cycles.
REQ-007 SHALL have port tx_o, output, 1 bit: serial line, idle high.
REQ-008 SHALL have port busy_o, output, 1 bit: high while a frame is in progress.
REQ-009 SHALL have port done_o, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-010 SHALL register ctl_i[0] each cycle (req_q) and detect a start request as ctl_i[0]=1 while req_q=0; a level held high SHALL start exactly one frame.
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; transitions: IDLE->START on start request; START->DATA after one bit period; DATA->PARITY after 8th bit if parity latched enabled, else DATA->STOP; PARITY->STOP after one bit period; STOP->IDLE after one bit period.
REQ-012 SHALL latch tx_data_i, ctl_i[1] and baud_div_i in the cycle the start request is detected; later changes to these inputs SHALL NOT affect the frame in progress.
REQ-013 SHALL make each bit period exactly latched baud_div + 1 clk_i cycles; baud_div = 0 SHALL give one cycle per bit.
REQ-014 SHALL drive tx_o low from the cycle after start detection (1-cycle latency) for the START bit, then data bits LSB first, then the parity bit (XOR of the 8 data bits, even parity) if enabled, then one high STOP bit.
REQ-015 SHALL drive tx_o from a register (no combinational path from inputs to tx_o).
REQ-016 SHALL assert busy_o from the first START cycle through the last STOP cycle, inclusive.
REQ-017 SHALL pulse done_o high for exactly one cycle, the first cycle after the STOP bit ends, concurrent with return to IDLE (busy_o low).
REQ-018 SHALL ignore start requests (rising edges of ctl_i[0]) detected while busy_o is high; they SHALL NOT be queued.
REQ-019 SHALL accept a new start request detected in the same cycle done_o pulses, with START beginning the next cycle.
REQ-020 SHALL use a DIV_W-bit down-counter for the bit period and a 3-bit bit index; neither SHALL wrap outside its state.

Reset
REQ-021 SHALL, with rst_ni low at a rising clk_i edge, set state IDLE, tx_o=1, busy_o=0, done_o=0, req_q=0, counters=0, latched registers=0.
REQ-022 SHALL abort any frame in progress on reset, with tx_o high from the first reset edge and no done_o pulse.
REQ-023 SHALL treat ctl_i[0]=1 in the first cycle after reset release as a start request (req_q=0).

Structure
REQ-024 SHALL place the FSM state enumeration, frame constants (DATA_BITS=8, idle level 1) and the DIV_W default in shared package uart_pkg.
REQ-025 SHALL factor the bit-period counter into sub-module uart_baud_gen (load, count, tick-at-zero output).

Verification
REQ-026 baud_div=3, ctl 0->01, data 0x55 -> tx_o: low 4 clk, then 1,0,1,0,1,0,1,0 at 4 clk each, high 4 clk; busy_o high 40 clk; done_o pulse at clk 41.
REQ-027 baud_div=3, ctl 0->11, data 0x07 -> parity bit 1 after data; busy_o 44 clk; done_o one pulse.
REQ-028 baud_div=0, ctl_i[0] held high 100 clk, data 0xA3 -> exactly one 10-clk frame, one done_o pulse.
REQ-029 during frame, ctl_i[0] toggled 1->0->1 and tx_data_i changed to 0xFF -> original frame unchanged, no second frame.
REQ-030 rst_ni low at DATA bit 3 -> tx_o=1, busy_o=0 next edge; no done_o; fresh request afterwards sends a full correct frame.
